// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD line arbiter slice.
package lcd_pkg;

    localparam int unsigned LINE_W     = 128;
    localparam logic [7:0]  CHAR_SPACE = 8'h20;
    localparam logic [LINE_W-1:0] BLANK_LINE = {16{CHAR_SPACE}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set request after last_gnt, wrapping.
module lcd_rr_pick #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [NREQ-1:0]  win,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((32'(last_gnt) + k) % NREQ);
            if (!any && req[idx]) begin
                win[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_line_arbiter.sv
// Arbitrates several text sources onto one two-line LCD, holding each grant
// for at least HOLD_CYCLES clocks with round-robin fairness.
module lcd_line_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LINE_W-1:0] line1_in,
    input  logic [NREQ*LINE_W-1:0] line2_in,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic [LINE_W-1:0]      LINE1,
    output logic [LINE_W-1:0]      LINE2,
    output logic                   refresh
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    arb_state_e         state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LINE_W-1:0]  line1_q, line1_d, line2_q, line2_d;
    logic               refresh_q, refresh_d;

    logic [NREQ-1:0]    pick_req, win, load_src;
    logic               any, load_en, expired, holder_req;
    logic [IDX_W-1:0]   win_idx;
    logic [LINE_W-1:0]  sel_l1, sel_l2;

    // While holding, the holder is masked so "any" means another requester waits.
    assign pick_req   = (state_q == ST_HOLD) ? (req & ~gnt_q) : req;
    assign expired    = (cnt_q == CNT_MAX);
    assign holder_req = |(req & gnt_q);

    lcd_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (pick_req),
        .last_gnt (last_q),
        .win      (win),
        .any      (any)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win[i]) win_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        load_en  = 1'b0;
        load_src = '0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d  = ST_HOLD;
                    gnt_d    = win;
                    last_d   = win_idx;
                    cnt_d    = '0;
                    load_en  = 1'b1;
                    load_src = win;
                end
            end
            ST_HOLD: begin
                if (expired && any) begin
                    gnt_d    = win;
                    last_d   = win_idx;
                    cnt_d    = '0;
                    load_en  = 1'b1;
                    load_src = win;
                end else if (expired && !holder_req) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else begin
                    if (!expired) cnt_d = cnt_q + 1'b1;
                    if (holder_req) begin
                        load_en  = 1'b1;
                        load_src = gnt_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sel_l1 = '0;
        sel_l2 = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (load_src[i]) begin
                sel_l1 = line1_in[i*LINE_W +: LINE_W];
                sel_l2 = line2_in[i*LINE_W +: LINE_W];
            end
        end
        line1_d   = load_en ? sel_l1 : line1_q;
        line2_d   = load_en ? sel_l2 : line2_q;
        refresh_d = load_en && ({sel_l1, sel_l2} != {line1_q, line2_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            last_q    <= IDX_W'(NREQ - 1);
            cnt_q     <= '0;
            line1_q   <= BLANK_LINE;
            line2_q   <= BLANK_LINE;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            line1_q   <= line1_d;
            line2_q   <= line2_d;
            refresh_q <= refresh_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == ST_HOLD);
    assign LINE1   = line1_q;
    assign LINE2   = line2_q;
    assign refresh = refresh_q;

endmodule

// File: doc/lcd_line_arbiter.md
LCD_LINE_ARBITER -- requirements
Module: lcd_line_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of display requesters (2..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50_000_000, minimum grant duration in clk cycles (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NREQ  per-requester display request, level.
REQ-006 SHALL have port line1_in  input  NREQ*128  requester i top-line text at bits [128*i+127:128*i], 16 ASCII chars, MSB char leftmost.
REQ-007 SHALL have port line2_in  input  NREQ*128  bottom-line text, same packing.
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, registered.
REQ-009 SHALL have port busy  output  1  high while in HOLD.
REQ-010 SHALL have port LINE1  output  128  registered top line to lcd_driver.
REQ-011 SHALL have port LINE2  output  128  registered bottom line to lcd_driver.
REQ-012 SHALL have port refresh  output  1  one-cycle pulse when LINE1/LINE2 change value.

Function
REQ-013 SHALL implement FSM states IDLE and HOLD only.
REQ-014 IDLE, req==0: SHALL stay IDLE, gnt=0, LINE1/LINE2 retained.
REQ-015 IDLE, any req at edge N: SHALL enter HOLD at N+1 with gnt one-hot on round-robin winner, LINE1/LINE2 = winner's inputs sampled at N, hold counter=0.
REQ-016 Round-robin search SHALL start at (last_gnt+1) mod NREQ and wrap; last_gnt updates on every grant.
REQ-017 HOLD: counter SHALL increment each cycle, saturating at HOLD_CYCLES-1.
REQ-018 HOLD with req[holder]=1: LINE1/LINE2 SHALL reload from holder's inputs every cycle (live view, 1-cycle latency).
REQ-019 HOLD with req[holder]=0 before expiry: SHALL keep gnt and freeze LINE1/LINE2 at last captured value until expiry.
REQ-020 Expiry = counter==HOLD_CYCLES-1; at expiry, if any other req pending, SHALL grant next round-robin winner in same edge (HOLD->HOLD, counter=0, new lines), no IDLE gap.
REQ-021 At expiry, no other req and req[holder]=0: SHALL go IDLE, gnt=0, lines retained.
REQ-022 At expiry, only holder requesting: SHALL keep grant indefinitely until another req or holder drop.
REQ-023 refresh SHALL pulse in the cycle after a load only if {LINE1,LINE2} value differs from the previous value.
REQ-024 busy SHALL equal (state==HOLD); gnt SHALL be 0 exactly when IDLE.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, gnt=0, busy=0, refresh=0, counter=0, last_gnt=NREQ-1 (requester 0 first), LINE1=LINE2=16 x 8'h20.
REQ-026 Reset mid-HOLD SHALL abort the grant immediately; first grant after release follows REQ-015 from requester 0 priority.
REQ-027 Deassertion SHALL be synchronised externally; no outputs change until first clk edge after release.

Structure
REQ-028 Shared package lcd_pkg SHALL hold LINE_W=128, CHAR_SPACE=8'h20, BLANK_LINE={16{CHAR_SPACE}}, state encoding.
REQ-029 Round-robin selection SHALL be one combinational sub-module lcd_rr_pick (inputs req, last_gnt; output one-hot winner, any).
REQ-030 LINE1/LINE2 SHALL connect directly to the existing lcd_driver line inputs at top level.

Verification (HOLD_CYCLES=4, NREQ=3)
REQ-031 Reset, no req -> LINE1=LINE2=all 8'h20, gnt=000, busy=0, refresh never pulses.
REQ-032 req=001 at edge 0 with line1_in[0]="REQ0..." -> edge 1 gnt=001, busy=1, LINE1 = requester 0 text; refresh pulses once.
REQ-033 req=111 held -> grants cycle 001,010,100,001 each lasting exactly 4 cycles, no IDLE gap.
REQ-034 req=010 granted, dropped after 1 cycle -> gnt=010 held to expiry (4 cycles), LINE frozen, then IDLE, gnt=000, lines retained.
REQ-035 Holder 001 alone beyond 10 cycles, then req=011 -> switch to 010 on next expiry-qualified edge; live update of requester 0 text visible with 1-cycle latency before switch.
REQ-036 rst_n low mid-HOLD at count 2 -> gnt=000, LINE blank immediately (async); after release req=110 -> gnt=010 first.
